// File: rtl/logic_sweep_checker_if.sv
// logic_sweep_checker_if
//   Bundle between the sweep checker and the three two-input logic
//   implementations it exercises.
//   master : checker side  (drives a/b and results, reads start and y*)
//   slave  : lab/host side (drives start and y*, reads a/b and results)
//   start            run request
//   a, b             stimulus to all implementations
//   y1s..y3s         structural outputs
//   y1d..y3d         dataflow outputs
//   y1b..y3b         behavioural outputs
//   busy, done, pass run status; done is a one-cycle pulse
//   err_count        saturating count of failing samples
//   first_fail_vec   {b,a} of the first failing sample
//   first_fail_mask  {y3,y2,y1} bits that failed at the first failing sample
interface logic_sweep_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic             y1s, y2s, y3s;
  logic             y1d, y2d, y3d;
  logic             y1b, y2b, y3b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       first_fail_vec;
  logic [2:0]       first_fail_mask;

  modport master (
    input  start, y1s, y2s, y3s, y1d, y2d, y3d, y1b, y2b, y3b,
    output a, b, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );

  modport slave (
    output start, y1s, y2s, y3s, y1d, y2d, y3d, y1b, y2b, y3b,
    input  a, b, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/logic_sweep_checker.sv
// logic_sweep_checker
//   Clocked truth-table sweep for the two-input lab modules. Walks {b,a}
//   through 0..3 for NUM_PASSES passes, holds each vector SETTLE_CYCLES
//   cycles, then compares the structural, dataflow and behavioural outputs
//   (and optionally a golden table) in a single SAMPLE cycle.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  checker side of logic_sweep_checker_if (see interface header)
module logic_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned CNT_W         = 8,
  parameter bit          CHECK_GOLDEN  = 1'b0,
  parameter logic [11:0] GOLDEN        = 12'h000
) (
  input logic                  clk,
  input logic                  rst,
  logic_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       PASS_LAST   = 4'(NUM_PASSES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       pass_cnt_q, pass_cnt_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [1:0]       ffv_q, ffv_d;
  logic [2:0]       ffm_q, ffm_d;
  logic             pass_q, pass_d;

  logic [2:0] ys, yd, yb, gold, fail;

  assign ys = {bus.y3s, bus.y2s, bus.y1s};
  assign yd = {bus.y3d, bus.y2d, bus.y1d};
  assign yb = {bus.y3b, bus.y2b, bus.y1b};

  always_comb begin
    gold = '0;
    case (vec_q)
      2'd0: gold = GOLDEN[2:0];
      2'd1: gold = GOLDEN[5:3];
      2'd2: gold = GOLDEN[8:6];
      2'd3: gold = GOLDEN[11:9];
      default: gold = '0;
    endcase
  end

  assign fail = (ys ^ yd) | (ys ^ yb)
              | ({3{CHECK_GOLDEN}} & ((ys ^ gold) | (yd ^ gold) | (yb ^ gold)));

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffm_d      = ffm_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d      = '0;
          ffv_d      = '0;
          ffm_d      = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          pass_cnt_d = '0;
          settle_d   = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
        else                         settle_d = settle_q + 4'd1;
      end
      SAMPLE: begin
        if (|fail) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          // err_count is cleared at start and never wraps, so zero means
          // no failure has been recorded yet in this run.
          if (err_q == '0) begin
            ffv_d = vec_q;
            ffm_d = fail;
          end
        end
        if (vec_q == 2'd3 && pass_cnt_q == PASS_LAST) begin
          state_d = DONE;
          // Registered here so pass is already valid in the DONE cycle.
          pass_d  = (err_d == '0);
        end else begin
          vec_d    = vec_q + 2'd1;
          settle_d = '0;
          if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + 4'd1;
          state_d  = SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      ffv_q      <= '0;
      ffm_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ffm_q      <= ffm_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.a               = vec_q[0];
  assign bus.b               = vec_q[1];
  assign bus.busy            = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;

endmodule
